// File: rtl/stage_5_output.sv
// stage_5_output: rectifies Laplacian sums to 8-bit pixels, tags row/col, and buffers them in a ready/valid FIFO
module stage_5_output #(
  parameter int N = 10,
  parameter int DEPTH = 8,
  parameter int MODE = 0,
  localparam int RW = $clog2(N-2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_add,
  input  logic signed [10:0]  convo_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [7:0]          out_pixel,
  output logic [RW-1:0]       out_row,
  output logic [RW-1:0]       out_col,
  output logic                out_last,
  output logic                frame_done,
  output logic                overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 2*RW + 8;
  localparam logic [RW-1:0] LAST_IDX = RW'(N-3);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [RW-1:0] row, col;
  logic [AW:0] wptr, rptr;
  logic [EW-1:0] mem [DEPTH];
  logic [10:0] mag;
  logic [7:0] pix;
  logic accept, last, empty, full, rd, wr;
  assign accept = start_add && (state == IDLE || state == RUN);
  assign last = row == LAST_IDX && col == LAST_IDX;
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign rd = !empty && out_ready;
  // a simultaneous read frees the slot, so a write into a full FIFO still lands
  assign wr = accept && (!full || rd);
  assign mag = convo_in[10] ? 11'(-convo_in) : convo_in;
  assign pix = (MODE == 0 && convo_in[10]) ? 8'd0 : (mag > 11'd255 ? 8'hff : mag[7:0]);
  assign out_valid = !empty;
  assign {out_last, out_row, out_col, out_pixel} = empty ? EW'(0) : mem[rptr[AW-1:0]];
  assign frame_done = state == DONE;
  always_comb begin
    state_nx = state;
    if (accept && last) state_nx = DRAIN;
    else if (state == IDLE && start_add) state_nx = RUN;
    else if (state == DRAIN && empty) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        col <= col == LAST_IDX ? '0 : col + 1'b1;
        row <= col == LAST_IDX ? row + 1'b1 : row;
      end
      if (accept && full && !rd) overflow <= 1'b1;
      if (wr) begin
        mem[wptr[AW-1:0]] <= {last, row, col, pix};
        wptr <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_stage_5_output.sv
// tb_stage_5_output: directed vectors plus multi-cycle sequences for stage_5_output
module tb_stage_5_output;
  logic clk = 0, reset = 0, start_add = 0, out_ready = 0;
  logic signed [10:0] convo_in = '0;
  logic v0, l0, fd0, ov0, v1, l1, fd1, ov1;
  logic [7:0] p0, p1;
  logic [2:0] r0, c0, r1, c1;
  int total = 0, bad = 0;

  stage_5_output #(.N(10), .DEPTH(8), .MODE(0)) d0 (.clk(clk), .reset(reset), .start_add(start_add),
    .convo_in(convo_in), .out_ready(out_ready), .out_valid(v0), .out_pixel(p0), .out_row(r0),
    .out_col(c0), .out_last(l0), .frame_done(fd0), .overflow(ov0));
  stage_5_output #(.N(10), .DEPTH(8), .MODE(1)) d1 (.clk(clk), .reset(reset), .start_add(start_add),
    .convo_in(convo_in), .out_ready(out_ready), .out_valid(v1), .out_pixel(p1), .out_row(r1),
    .out_col(c1), .out_last(l1), .frame_done(fd1), .overflow(ov1));

  always #5 clk = ~clk;

  typedef struct {int cin; int px0; int px1; int row; int col;} vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0; start_add = 0; out_ready = 0; convo_in = '0;
    tick(); tick();
    chk("rst_valid", v0, 0); chk("rst_pixel", p0, 0); chk("rst_done", fd0, 0);
    chk("rst_ovf", ov0, 0); chk("rst_last", l0, 0);
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{-4, 0, 4, 0, 0};
    vt[1] = '{0, 0, 0, 0, 1};
    vt[2] = '{100, 100, 100, 0, 2};
    vt[3] = '{300, 255, 255, 0, 3};
    vt[4] = '{-1020, 0, 255, 0, 4};
    vt[5] = '{1020, 255, 255, 0, 5};
    do_reset();
    // rectification table, both modes side by side, one-cycle latency
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      start_add = 1; convo_in = 11'(vt[i].cin);
      tick();
      chk("vec_valid", v0, 1);
      chk("vec_px_mode0", p0, vt[i].px0);
      chk("vec_px_mode1", p1, vt[i].px1);
      chk("vec_row", r0, vt[i].row);
      chk("vec_col", c0, vt[i].col);
    end
    // full frame of 64 samples
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      start_add = 1; convo_in = 11'(i);
      tick();
      chk("frame_valid", v0, 1);
      chk("frame_pixel", p0, i);
      chk("frame_row", r0, i / 8);
      chk("frame_col", c0, i % 8);
      chk("frame_last", l0, i == 63 ? 1 : 0);
    end
    convo_in = 11'd77;
    tick();
    chk("frame_65_ignored", v0, 0);
    chk("frame_done_early", fd0, 0);
    tick();
    chk("frame_done", fd0, 1);
    chk("frame_done_ovf", ov0, 0);
    tick(); tick();
    chk("done_still_empty", v0, 0);
    chk("done_holds", fd0, 1);
    #2 reset = 0; #1;
    chk("async_rst_done", fd0, 0);
    // fill with consumer stalled, then overflow
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      start_add = 1; convo_in = 11'(10 + i);
      tick();
      chk("stall_valid", v0, 1);
      chk("stall_head_px", p0, 10);
      chk("stall_head_col", c0, 0);
      chk("stall_ovf", ov0, 0);
    end
    convo_in = 11'd18;
    tick();
    chk("ovf_set", ov0, 1);
    start_add = 0; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", v0, 1);
      chk("drain_px", p0, 10 + k);
      chk("drain_row", r0, 0);
      chk("drain_col", c0, k);
      tick();
    end
    chk("drain_empty", v0, 0);
    chk("ovf_sticky", ov0, 1);
    // full FIFO with simultaneous read and write
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      start_add = 1; convo_in = 11'(i);
      tick();
    end
    out_ready = 1; convo_in = 11'd50;
    tick();
    chk("rw_full_ovf", ov0, 0);
    chk("rw_full_head", c0, 1);
    out_ready = 0; convo_in = 11'd51;
    tick();
    chk("rw_still_full", ov0, 1);
    // bubbles and mid-frame reset
    do_reset();
    out_ready = 1;
    start_add = 1; convo_in = 11'd1; tick();
    chk("tog_col0", c0, 0); chk("tog_px0", p0, 1);
    start_add = 0; tick();
    chk("tog_bubble", v0, 0);
    start_add = 1; convo_in = 11'd2; tick();
    chk("tog_col1", c0, 1); chk("tog_px1", p0, 2);
    start_add = 0; tick();
    chk("tog_bubble2", v0, 0);
    out_ready = 0; start_add = 1;
    for (int i = 0; i < 9; i++) begin
      convo_in = 11'(i); tick();
    end
    chk("mid_ovf_pre", ov0, 1);
    #2 reset = 0; #1;
    chk("mid_rst_valid", v0, 0);
    chk("mid_rst_ovf", ov0, 0);
    chk("mid_rst_done", fd0, 0);
    start_add = 0; tick();
    reset = 1; start_add = 1; out_ready = 1; convo_in = 11'd7;
    tick();
    chk("post_rst_row", r0, 0);
    chk("post_rst_col", c0, 0);
    chk("post_rst_px", p0, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
